register_file: RTL and testbench
================================

// Module: register_file
// PURPOSE
//   Decode-stage MIPS general-purpose register file: 32 x 32-bit storage, two
//   combinational read ports and one write port driven by writeback.
//   Carries a per-register pending-write scoreboard, set when decode issues an
//   instruction and cleared when writeback delivers the value.
//   Decode uses the per-port ready flags to stall until its operands are valid.
//   Write-through bypass lets a value written this cycle be read this cycle.
// PARAMETERS
//   DATA_WIDTH   32  width of each register
//   NUM_REGS     32  number of registers; index 0 is hardwired to zero
//   ADDR_WIDTH   5   register index width, equal to log2(NUM_REGS)
//   START_VALUE  0   value loaded into every register at reset
// PORTS
//   clock         in   1    single clock; all state updates on posedge
//   reset         in   1    asynchronous, active-high
//   read_addr_a   in   5    read port A index (rs)
//   read_addr_b   in   5    read port B index (rt)
//   read_value_a  out  32   port A data, combinational
//   read_value_b  out  32   port B data, combinational
//   ready_a       out  1    port A data is final (not pending)
//   ready_b       out  1    port B data is final (not pending)
//   should_write  in   1    writeback commits new_value at the next posedge
//   write_addr    in   5    writeback destination index
//   new_value     in   32   writeback data
//   claim         in   1    decode issues an instruction that writes claim_addr
//   claim_addr    in   5    destination being claimed
//   claim_stall   out  1    claim rejected this cycle; decode must hold
// BEHAVIOUR
//   - Reset (asynchronous, active-high): every register <= START_VALUE; all busy
//     bits <= 0. While reset is asserted, read_value_* = START_VALUE (index 0
//     reads 0), ready_* = 1, claim_stall = 0. Writes and claims are ignored.
//   - Read: read_value_x = regs[addr], with two overrides:
//     - addr == 0 always returns 0.
//     - If should_write && write_addr == addr && addr != 0, returns new_value
//       (bypass, zero-cycle latency).
//   - Ready: ready_x = !busy[addr] || (should_write && write_addr == addr).
//     Index 0 is always ready.
//   - Write: at posedge, if should_write && write_addr != 0, regs[write_addr]
//     <= new_value. Writes to index 0 are discarded.
//   - Scoreboard (next-state per index i; busy[0] is constant 0):
//       set_i = claim && !claim_stall && claim_addr == i && i != 0
//       clr_i = should_write && write_addr == i
//       busy[i] <= set_i ? 1 : (clr_i ? 0 : busy[i])
//     When set and clear hit the same index in one cycle, set wins: the newer
//     instruction owns the register.
//   - claim_stall = claim && claim_addr != 0 && busy[claim_addr]
//                   && !(should_write && write_addr == claim_addr).
//     This allows one outstanding write per register (WAW protection).
//     A stalled claim changes no state.
//   - A write to a register that is not busy is legal: it updates data and
//     busy stays 0.
//   - Reset asserted mid-operation clears all pending claims immediately.
//     A write or claim in the same cycle as reset release is honoured only
//     from the first posedge after release.
// STRUCTURE
//   - Shared package: REG_ZERO (5'd0), REG_RA (5'd31), DATA_WIDTH, ADDR_WIDTH,
//     and a reg_index_t typedef.
//   - One natural sub-module, regfile_read_port, instantiated twice. It takes
//     addr, regs, busy and the write bus, and produces value and ready.
//   - Storage is a flop array rather than RAM, because reads are asynchronous
//     and reset must clear every entry.
// TESTING
//   - Reset, then read all 32 indices -> value 0 and ready 1. Write 0xDEADBEEF
//     to r0, then read r0 -> 0.
//   - Write r5 = 0x12345678 with read_addr_a = 5 in the same cycle -> port A
//     shows 0x12345678 combinationally. The next cycle, with should_write = 0,
//     port A still shows 0x12345678.
//   - claim r8, next cycle read_addr_b = 8 -> ready_b = 0 until writeback
//     r8 = 0xA5A5A5A5. In that writeback cycle ready_b = 1 with the bypassed
//     value.
//   - r9 busy, claim r9 again with no write -> claim_stall = 1 and state is
//     unchanged. Repeat in the cycle r9 is written -> claim_stall = 0 and r9
//     stays busy afterwards (set wins).
//   - claim r3, then assert reset mid-flight without a clock edge -> ready_a
//     for r3 rises to 1 immediately and all registers read 0.
//   - Randomised 10k cycles against a reference model: every read value and
//     ready matches, and claim_stall is asserted only on a busy destination.

Source files
------------

// File: rtl/register_file_pkg.sv
// register_file_pkg: shared widths, well-known register indices and index type
package register_file_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 1 << ADDR_WIDTH;
    typedef logic [ADDR_WIDTH-1:0] reg_index_t;
    localparam reg_index_t REG_ZERO = 5'd0;
    localparam reg_index_t REG_RA   = 5'd31;
endpackage

// File: rtl/register_file_if.sv
// register_file_if: decode/writeback bus of the register file
interface register_file_if;
    import register_file_pkg::*;
    reg_index_t              read_addr_a;
    reg_index_t              read_addr_b;
    logic [DATA_WIDTH-1:0]   read_value_a;
    logic [DATA_WIDTH-1:0]   read_value_b;
    logic                    ready_a;
    logic                    ready_b;
    logic                    should_write;
    reg_index_t              write_addr;
    logic [DATA_WIDTH-1:0]   new_value;
    logic                    claim;
    reg_index_t              claim_addr;
    logic                    claim_stall;
    modport master (
        output read_addr_a, read_addr_b, should_write, write_addr, new_value, claim, claim_addr,
        input  read_value_a, read_value_b, ready_a, ready_b, claim_stall
    );
    modport slave (
        input  read_addr_a, read_addr_b, should_write, write_addr, new_value, claim, claim_addr,
        output read_value_a, read_value_b, ready_a, ready_b, claim_stall
    );
endinterface

// File: rtl/register_file_read_port.sv
// regfile_read_port: one combinational read port with r0 forcing and write-through bypass
module regfile_read_port #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic [ADDR_WIDTH-1:0]                addr,
    input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs,
    input  logic [NUM_REGS-1:0]                  busy,
    input  logic                                 write_en,
    input  logic [ADDR_WIDTH-1:0]                write_addr,
    input  logic [DATA_WIDTH-1:0]                write_data,
    output logic [DATA_WIDTH-1:0]                value,
    output logic                                 ready
);
    import register_file_pkg::*;
    logic is_zero;
    logic hit;
    // r0 reads zero and is always final; a same-cycle write supplies both data and readiness
    always_comb begin
        is_zero = addr == REG_ZERO;
        hit     = write_en && write_addr == addr;
        value   = is_zero ? '0 : (hit ? write_data : regs[addr]);
        ready   = is_zero || !busy[addr] || hit;
    end
endmodule

// File: rtl/register_file.sv
// register_file: 32x32 MIPS register file with pending-write scoreboard and bypass
module register_file #(
    parameter int                 DATA_WIDTH  = 32,
    parameter int                 NUM_REGS    = 32,
    parameter int                 ADDR_WIDTH  = 5,
    parameter logic [DATA_WIDTH-1:0] START_VALUE = '0
) (
    input logic              clock,
    input logic              reset,
    register_file_if.slave   bus
);
    import register_file_pkg::*;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
    logic [NUM_REGS-1:0]                 busy;
    logic                                write_en;
    logic                                claim_ok;
    // Writes are masked during reset so the bypass cannot leak new_value while held in reset;
    // a claim stalls only on a busy register that is not being delivered this cycle
    always_comb begin
        write_en        = bus.should_write && !reset;
        bus.claim_stall = bus.claim && !reset && bus.claim_addr != REG_ZERO && busy[bus.claim_addr]
                          && !(write_en && bus.write_addr == bus.claim_addr);
        claim_ok        = bus.claim && !bus.claim_stall && bus.claim_addr != REG_ZERO;
    end
    // Storage and scoreboard; index 0 is never written and its busy bit stays clear; a claim beats a clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            regs <= {NUM_REGS{START_VALUE}};
            busy <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (write_en && bus.write_addr == ADDR_WIDTH'(i))
                    regs[i] <= bus.new_value;
                if (claim_ok && bus.claim_addr == ADDR_WIDTH'(i))
                    busy[i] <= 1'b1;
                else if (write_en && bus.write_addr == ADDR_WIDTH'(i))
                    busy[i] <= 1'b0;
            end
        end
    end
    regfile_read_port #(.DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS), .ADDR_WIDTH(ADDR_WIDTH)) u_port_a (
        .addr(bus.read_addr_a), .regs(regs), .busy(busy),
        .write_en(write_en), .write_addr(bus.write_addr), .write_data(bus.new_value),
        .value(bus.read_value_a), .ready(bus.ready_a)
    );
    regfile_read_port #(.DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS), .ADDR_WIDTH(ADDR_WIDTH)) u_port_b (
        .addr(bus.read_addr_b), .regs(regs), .busy(busy),
        .write_en(write_en), .write_addr(bus.write_addr), .write_data(bus.new_value),
        .value(bus.read_value_b), .ready(bus.ready_b)
    );
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed vector table, reset corner cases and randomized model comparison
module tb_register_file;
    import register_file_pkg::*;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] mregs [32];
    bit          mbusy [32];
    register_file_if bus ();
    register_file dut (.clock(clock), .reset(reset), .bus(bus.slave));
    always #5 clock = ~clock;
    typedef struct {
        logic        sw;
        logic [4:0]  wa;
        logic [31:0] nv;
        logic        cl;
        logic [4:0]  ca;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] ev_a;
        logic [31:0] ev_b;
        logic        er_a;
        logic        er_b;
        logic        e_stall;
    } vec_t;
    vec_t vecs [19];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic drive(input logic sw, input logic [4:0] wa, input logic [31:0] nv,
                         input logic cl, input logic [4:0] ca, input logic [4:0] ra, input logic [4:0] rb);
        bus.should_write = sw;
        bus.write_addr   = wa;
        bus.new_value    = nv;
        bus.claim        = cl;
        bus.claim_addr   = ca;
        bus.read_addr_a  = ra;
        bus.read_addr_b  = rb;
    endtask
    function automatic logic [31:0] m_val(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (bus.should_write && bus.write_addr == a) return bus.new_value;
        return mregs[a];
    endfunction
    function automatic logic m_rdy(input logic [4:0] a);
        return a == 0 || !mbusy[a] || (bus.should_write && bus.write_addr == a);
    endfunction
    function automatic logic m_stall();
        return bus.claim && bus.claim_addr != 0 && mbusy[bus.claim_addr]
               && !(bus.should_write && bus.write_addr == bus.claim_addr);
    endfunction
    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            mregs[i] = 32'h0;
            mbusy[i] = 1'b0;
        end
    endtask
    task automatic tick();
        logic st;
        @(posedge clock);
        if (reset) model_clear();
        else begin
            st = m_stall();
            if (bus.should_write) begin
                if (bus.write_addr != 0) mregs[bus.write_addr] = bus.new_value;
                mbusy[bus.write_addr] = 1'b0;
            end
            if (bus.claim && !st && bus.claim_addr != 0) mbusy[bus.claim_addr] = 1'b1;
        end
        #1;
    endtask
    function automatic logic [4:0] rand_addr();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    endfunction
    initial begin
        vecs[0]  = '{1, 0,  32'hDEADBEEF, 0, 0,  0,  0,  32'h0,        32'h0,        1, 1, 0};
        vecs[1]  = '{0, 0,  32'h0,        0, 0,  0,  5,  32'h0,        32'h0,        1, 1, 0};
        vecs[2]  = '{1, 5,  32'h12345678, 0, 0,  5,  5,  32'h12345678, 32'h12345678, 1, 1, 0};
        vecs[3]  = '{0, 0,  32'h0,        0, 0,  5,  6,  32'h12345678, 32'h0,        1, 1, 0};
        vecs[4]  = '{0, 0,  32'h0,        1, 8,  8,  8,  32'h0,        32'h0,        1, 1, 0};
        vecs[5]  = '{0, 0,  32'h0,        0, 0,  5,  8,  32'h12345678, 32'h0,        1, 0, 0};
        vecs[6]  = '{0, 0,  32'h0,        0, 0,  8,  8,  32'h0,        32'h0,        0, 0, 0};
        vecs[7]  = '{1, 8,  32'hA5A5A5A5, 0, 0,  5,  8,  32'h12345678, 32'hA5A5A5A5, 1, 1, 0};
        vecs[8]  = '{0, 0,  32'h0,        0, 0,  8,  8,  32'hA5A5A5A5, 32'hA5A5A5A5, 1, 1, 0};
        vecs[9]  = '{0, 0,  32'h0,        1, 9,  9,  8,  32'h0,        32'hA5A5A5A5, 1, 1, 0};
        vecs[10] = '{0, 0,  32'h0,        1, 9,  9,  9,  32'h0,        32'h0,        0, 0, 1};
        vecs[11] = '{1, 9,  32'h00000099, 1, 9,  9,  8,  32'h00000099, 32'hA5A5A5A5, 1, 1, 0};
        vecs[12] = '{0, 0,  32'h0,        0, 0,  9,  9,  32'h00000099, 32'h00000099, 0, 0, 0};
        vecs[13] = '{1, 9,  32'h00000077, 0, 0,  9,  0,  32'h00000077, 32'h0,        1, 1, 0};
        vecs[14] = '{0, 0,  32'h0,        0, 0,  9,  5,  32'h00000077, 32'h12345678, 1, 1, 0};
        vecs[15] = '{0, 0,  32'h0,        1, 0,  0,  0,  32'h0,        32'h0,        1, 1, 0};
        vecs[16] = '{0, 0,  32'h0,        0, 0,  0,  REG_RA, 32'h0,    32'h0,        1, 1, 0};
        vecs[17] = '{1, REG_RA, 32'hFFFFFFFF, 1, REG_RA, REG_RA, 30, 32'hFFFFFFFF, 32'h0, 1, 1, 0};
        vecs[18] = '{0, 0,  32'h0,        0, 0,  REG_RA, REG_RA, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0};
        model_clear();
        drive(1, 5, 32'hCAFEF00D, 1, 5, 5, 0);
        #2;
        chk("reset_bypass_masked", bus.read_value_a, 32'h0);
        chk("reset_ready_a", 32'(bus.ready_a), 32'h1);
        chk("reset_stall", 32'(bus.claim_stall), 32'h0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bus.read_addr_a = 5'(i);
            bus.read_addr_b = 5'(31 - i);
            #1;
            chk("post_reset_val_a", bus.read_value_a, 32'h0);
            chk("post_reset_rdy_b", 32'(bus.ready_b), 32'h1);
        end
        for (int v = 0; v < 19; v++) begin
            drive(vecs[v].sw, vecs[v].wa, vecs[v].nv, vecs[v].cl, vecs[v].ca, vecs[v].ra, vecs[v].rb);
            #1;
            chk($sformatf("vec%0d_val_a", v), bus.read_value_a, vecs[v].ev_a);
            chk($sformatf("vec%0d_val_b", v), bus.read_value_b, vecs[v].ev_b);
            chk($sformatf("vec%0d_rdy_a", v), 32'(bus.ready_a), 32'(vecs[v].er_a));
            chk($sformatf("vec%0d_rdy_b", v), 32'(bus.ready_b), 32'(vecs[v].er_b));
            chk($sformatf("vec%0d_stall", v), 32'(bus.claim_stall), 32'(vecs[v].e_stall));
            tick();
        end
        drive(0, 0, 0, 1, 3, 3, 0);
        tick();
        drive(0, 0, 0, 0, 0, 3, 0);
        #1;
        chk("r3_pending", 32'(bus.ready_a), 32'h0);
        reset = 1'b1;
        #1;
        chk("r3_ready_async_reset", 32'(bus.ready_a), 32'h1);
        model_clear();
        for (int i = 0; i < 32; i++) begin
            bus.read_addr_b = 5'(i);
            #1;
            chk("async_reset_clear", bus.read_value_b, 32'h0);
        end
        @(negedge clock);
        reset = 1'b0;
        drive(0, 0, 0, 1, 4, 4, 0);
        #1;
        chk("release_claim_no_stall", 32'(bus.claim_stall), 32'h0);
        chk("release_claim_not_yet", 32'(bus.ready_a), 32'h1);
        tick();
        drive(0, 0, 0, 0, 0, 4, 0);
        #1;
        chk("release_claim_taken", 32'(bus.ready_a), 32'h0);
        for (int c = 0; c < 10000; c++) begin
            drive($urandom_range(0, 2) == 0, rand_addr(), $urandom(), $urandom_range(0, 1) == 1,
                  rand_addr(), rand_addr(), rand_addr());
            #1;
            chk("rnd_val_a", bus.read_value_a, m_val(bus.read_addr_a));
            chk("rnd_val_b", bus.read_value_b, m_val(bus.read_addr_b));
            chk("rnd_rdy_a", 32'(bus.ready_a), 32'(m_rdy(bus.read_addr_a)));
            chk("rnd_rdy_b", 32'(bus.ready_b), 32'(m_rdy(bus.read_addr_b)));
            chk("rnd_stall", 32'(bus.claim_stall), 32'(m_stall()));
            tick();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
